// File: rtl/axis_data_unpackage_if.sv
// Purpose: AXI-Stream beat bundle for the H2C receive path.
//   master: drives tdata/tkeep/tlast/tvalid, samples tready
//   slave : samples tdata/tkeep/tlast/tvalid, drives tready
interface axis_data_unpackage_if #(
  parameter int AXIS_DATA_WIDTH = 512
);
  logic [AXIS_DATA_WIDTH-1:0]   tdata;
  logic [AXIS_DATA_WIDTH/8-1:0] tkeep;
  logic                         tlast;
  logic                         tvalid;
  logic                         tready;

  modport master (output tdata, tkeep, tlast, tvalid, input tready);
  modport slave  (input tdata, tkeep, tlast, tvalid, output tready);
endinterface

// File: rtl/axis_data_unpackage.sv
// Purpose: H2C stream unpacker. Reassembles AXIS beats into DATA_WIDTH-bit
//   records, strips/checks the 8-bit sequence byte at record bits [7:0],
//   checks tlast framing, and presents records on a valid/ready port.
// Ports:
//   s_axis_h2c_aclk/aresetn : clock, async active-low reset
//   s_axis_h2c              : AXIS slave (tdata/tkeep/tlast/tvalid in, tready out)
//   data_out/_valid/_ready  : record output handshake
//   seq_err_cnt/frame_err_cnt : saturating error counters
//   rstate                  : one-hot FSM state (COLLECT/HOLD/DROP)
// A record must span at least two beats (DATA_WIDTH > AXIS_DATA_WIDTH-8):
// the one-cycle load stage relies on no second completion in the cycle
// after a completion.
module axis_data_unpackage #(
  parameter int DATA_WIDTH        = 16000,
  parameter int AXIS_DATA_WIDTH   = 512,
  parameter int RECORDS_PER_BURST = 8
)(
  input  logic                    s_axis_h2c_aclk,
  input  logic                    s_axis_h2c_aresetn,
  axis_data_unpackage_if.slave    s_axis_h2c,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    data_out_valid,
  input  logic                    data_out_ready,
  output logic [15:0]             seq_err_cnt,
  output logic [15:0]             frame_err_cnt,
  output logic [2:0]              rstate
);
  localparam int BEATS = (DATA_WIDTH + 8 + AXIS_DATA_WIDTH - 1) / AXIS_DATA_WIDTH;
  localparam int BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int RCW   = (RECORDS_PER_BURST > 1) ? $clog2(RECORDS_PER_BURST) : 1;
  localparam logic [BCW-1:0] LAST_BEAT = BCW'(BEATS - 1);
  localparam logic [RCW-1:0] LAST_REC  = RCW'(RECORDS_PER_BURST - 1);

  typedef enum logic [2:0] {
    ST_COLLECT = 3'b001,
    ST_HOLD    = 3'b010,
    ST_DROP    = 3'b100
  } state_e;

  state_e                                  state_q;
  logic                                    tready_q;
  logic                                    pend_q;       // complete record waiting one cycle to load
  logic                                    drop_pend_q;  // enter DROP once HOLD releases
  logic [BCW-1:0]                          beat_cnt_q;
  logic [RCW-1:0]                          rec_cnt_q;
  logic [7:0]                              exp_seq_q;
  logic [15:0]                             seq_err_q;
  logic [15:0]                             frame_err_q;
  logic [DATA_WIDTH-1:0]                   dout_q;
  logic                                    dout_valid_q;
  logic [BEATS-1:0][AXIS_DATA_WIDTH-1:0]   asm_q;

  logic                                    beat_acc, beat_last, rec_last, slot_free, no_tlast_end;
  logic [7:0]                              seq_in;
  logic [BEATS*AXIS_DATA_WIDTH-1:0]        rec_flat;
  logic [DATA_WIDTH-1:0]                   payload;
  logic                                    unused_bits;

  assign beat_acc     = s_axis_h2c.tvalid && tready_q;
  assign beat_last    = (beat_cnt_q == LAST_BEAT);
  assign rec_last     = (rec_cnt_q == LAST_REC);
  assign no_tlast_end = rec_last && !s_axis_h2c.tlast;
  // Slot counts as free only if it is empty now (or drains this edge) and
  // nothing is already queued to load into it.
  assign slot_free    = (!dout_valid_q || data_out_ready) && !pend_q;
  // Sequence byte lives in beat 0; on a single-beat record it is still on the bus.
  assign seq_in       = (beat_cnt_q == '0) ? s_axis_h2c.tdata[7:0] : asm_q[0][7:0];
  assign rec_flat     = asm_q;
  assign payload      = rec_flat[8 +: DATA_WIDTH];
  // tkeep is ignored and pad bits above the payload are don't-care.
  assign unused_bits  = ^{s_axis_h2c.tkeep, rec_flat};

  assign s_axis_h2c.tready = tready_q;
  assign data_out          = dout_q;
  assign data_out_valid    = dout_valid_q;
  assign seq_err_cnt       = seq_err_q;
  assign frame_err_cnt     = frame_err_q;
  assign rstate            = state_q;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge s_axis_h2c_aclk or negedge s_axis_h2c_aresetn) begin
    if (!s_axis_h2c_aresetn) begin
      state_q      <= ST_COLLECT;
      tready_q     <= 1'b1;
      pend_q       <= 1'b0;
      drop_pend_q  <= 1'b0;
      beat_cnt_q   <= '0;
      rec_cnt_q    <= '0;
      exp_seq_q    <= '0;
      seq_err_q    <= '0;
      frame_err_q  <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      asm_q        <= '0;
    end else begin
      // Output slot: queued load wins over drain so back-to-back delivery works.
      if (pend_q) begin
        dout_q       <= payload;
        dout_valid_q <= 1'b1;
        pend_q       <= 1'b0;
      end else if (dout_valid_q && data_out_ready) begin
        dout_valid_q <= 1'b0;
      end

      case (state_q)
        ST_COLLECT: if (beat_acc) begin
          if (s_axis_h2c.tlast && !(beat_last && rec_last)) begin
            // Early/misplaced tlast: throw away the partial record, resync burst.
            frame_err_q <= sat_inc(frame_err_q);
            beat_cnt_q  <= '0;
            rec_cnt_q   <= '0;
          end else begin
            asm_q[beat_cnt_q] <= s_axis_h2c.tdata;
            if (!beat_last) begin
              beat_cnt_q <= beat_cnt_q + 1'b1;
            end else begin
              beat_cnt_q <= '0;
              rec_cnt_q  <= rec_last ? '0 : rec_cnt_q + 1'b1;
              if (seq_in != exp_seq_q) seq_err_q <= sat_inc(seq_err_q);
              exp_seq_q  <= seq_in + 8'd1;  // always follow the sender
              if (no_tlast_end) frame_err_q <= sat_inc(frame_err_q);
              if (slot_free) begin
                pend_q <= 1'b1;
                if (no_tlast_end) state_q <= ST_DROP;
              end else begin
                state_q     <= ST_HOLD;
                tready_q    <= 1'b0;
                drop_pend_q <= no_tlast_end;
              end
            end
          end
        end
        ST_HOLD: if (slot_free) begin
          dout_q       <= payload;
          dout_valid_q <= 1'b1;
          tready_q     <= 1'b1;
          drop_pend_q  <= 1'b0;
          state_q      <= drop_pend_q ? ST_DROP : ST_COLLECT;
        end
        ST_DROP: if (beat_acc && s_axis_h2c.tlast) begin
          state_q <= ST_COLLECT;
        end
        default: begin
          state_q  <= ST_COLLECT;
          tready_q <= 1'b1;
        end
      endcase
    end
  end
endmodule
